order_queue: RTL and testbench

ORDER_QUEUE -- requirements
Module: order_queue

---
 rtl/order_queue.sv | 120 ++++++++++++
 tb/tb_order_queue.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/order_queue.sv
// order_queue: circular order buffer between the order generator and the matching engine.
// It supports hold and flush control and keeps a saturating count of dropped orders.
module order_queue #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned PW    = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [PW-1:0]            in_buy,
    input  logic [PW-1:0]            in_sell,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [PW-1:0]            out_buy,
    output logic [PW-1:0]            out_sell,
    input  logic                     out_ready,
    input  logic                     hold,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty,
    output logic [7:0]               drop_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_HOLD  = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t          r_state;
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [LW-1:0]   r_level;
    logic [7:0]      r_drop;
    logic [PW-1:0]   r_buy_mem  [DEPTH];
    logic [PW-1:0]   r_sell_mem [DEPTH];

    logic            w_full;
    logic            w_empty;
    logic            w_in_ready;
    logic            w_out_valid;
    logic            w_push;
    logic            w_pop;
    logic            w_drop;

    // Handshake and status decode from registered state and level
    assign w_full      = (r_level == LW'(DEPTH));
    assign w_empty     = (r_level == LW'(0));
    assign w_in_ready  = !w_full && (r_state != ST_FLUSH);
    assign w_out_valid = !w_empty && (r_state == ST_RUN);
    assign w_push      = in_valid && w_in_ready && (in_buy != '0) && (in_sell != '0);
    assign w_pop       = w_out_valid && out_ready;
    assign w_drop      = in_valid && !w_push;

    assign in_ready    = w_in_ready;
    assign out_valid   = w_out_valid;
    assign full        = w_full;
    assign empty       = w_empty;
    assign level       = r_level;
    assign drop_count  = r_drop;
    assign out_buy     = w_empty ? '0 : r_buy_mem[r_rd_ptr];
    assign out_sell    = w_empty ? '0 : r_sell_mem[r_rd_ptr];

    // Control FSM: flush wins over hold, and the flush state lasts one cycle unless flush is held
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_RUN;
        end else begin
            case (r_state)
                ST_RUN:   r_state <= flush ? ST_FLUSH : (hold ? ST_HOLD : ST_RUN);
                ST_HOLD:  r_state <= flush ? ST_FLUSH : (hold ? ST_HOLD : ST_RUN);
                ST_FLUSH: r_state <= flush ? ST_FLUSH : (hold ? ST_HOLD : ST_RUN);
                default:  r_state <= ST_RUN;
            endcase
        end
    end

    // Pointer and level bookkeeping; the flush cycle empties the queue
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (r_state == ST_FLUSH) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // Saturating count of orders lost to overflow, flush or zero prices
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_drop <= '0;
        end else if (w_drop && (r_drop != 8'hFF)) begin
            r_drop <= r_drop + 8'd1;
        end
    end

    // Order storage, not reset: only entries between the pointers are ever read
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_buy_mem[r_wr_ptr]  <= in_buy;
            r_sell_mem[r_wr_ptr] <= in_sell;
        end
    end

endmodule

// File: tb/tb_order_queue.sv
// tb_order_queue: directed scenarios plus random traffic compared against a queue-based model.
module tb_order_queue;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned PW    = 8;
    localparam int unsigned LW    = $clog2(DEPTH) + 1;

    localparam int M_RUN   = 0;
    localparam int M_HOLD  = 1;
    localparam int M_FLUSH = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic            in_valid;
    logic [PW-1:0]   in_buy;
    logic [PW-1:0]   in_sell;
    logic            in_ready;
    logic            out_valid;
    logic [PW-1:0]   out_buy;
    logic [PW-1:0]   out_sell;
    logic            out_ready;
    logic            hold;
    logic            flush;
    logic [LW-1:0]   level;
    logic            full;
    logic            empty;
    logic [7:0]      drop_count;

    int n_chk = 0;
    int n_err = 0;

    // Reference model: FIFO of {buy,sell}, control mode, drop count
    logic [2*PW-1:0] mq[$];
    int              m_mode;
    int              m_drops;

    order_queue #(.DEPTH(DEPTH), .PW(PW)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_buy     (in_buy),
        .in_sell    (in_sell),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_buy    (out_buy),
        .out_sell   (out_sell),
        .out_ready  (out_ready),
        .hold       (hold),
        .flush      (flush),
        .level      (level),
        .full       (full),
        .empty      (empty),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_mode  = M_RUN;
        m_drops = 0;
    endtask

    // Compare every DUT output with what the model says for the current cycle
    task automatic check_outputs();
        int              sz;
        logic            e_rdy;
        logic            e_ov;
        logic [2*PW-1:0] head;
        sz    = mq.size();
        e_rdy = (sz < int'(DEPTH)) && (m_mode != M_FLUSH);
        e_ov  = (sz > 0) && (m_mode == M_RUN);
        head  = (sz > 0) ? mq[0] : '0;
        chk("in_ready",   32'(in_ready),   32'(e_rdy));
        chk("out_valid",  32'(out_valid),  32'(e_ov));
        chk("out_buy",    32'(out_buy),    32'(head[2*PW-1:PW]));
        chk("out_sell",   32'(out_sell),   32'(head[PW-1:0]));
        chk("level",      32'(level),      32'(sz));
        chk("full",       32'(full),       32'(sz == int'(DEPTH)));
        chk("empty",      32'(empty),      32'(sz == 0));
        chk("drop_count", 32'(drop_count), 32'(m_drops));
    endtask

    // One clock cycle: apply inputs, check, advance the model across the edge
    task automatic step(input logic v, input logic [PW-1:0] b, input logic [PW-1:0] s,
                        input logic ordy, input logic hld, input logic fl);
        int   sz;
        logic e_rdy;
        logic e_ov;
        logic push_ok;
        logic pop_ok;
        in_valid  = v;
        in_buy    = b;
        in_sell   = s;
        out_ready = ordy;
        hold      = hld;
        flush     = fl;
        #3;
        check_outputs();
        sz      = mq.size();
        e_rdy   = (sz < int'(DEPTH)) && (m_mode != M_FLUSH);
        e_ov    = (sz > 0) && (m_mode == M_RUN);
        push_ok = v && e_rdy && (b != 0) && (s != 0);
        pop_ok  = e_ov && ordy;
        if (v && !push_ok && m_drops < 255) m_drops++;
        if (m_mode == M_FLUSH) begin
            mq.delete();
        end else begin
            if (pop_ok)  void'(mq.pop_front());
            if (push_ok) mq.push_back({b, s});
        end
        m_mode = fl ? M_FLUSH : (hld ? M_HOLD : M_RUN);
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset applied between edges; outputs must clear without a clock edge
    task automatic reset_mid();
        reset = 1'b1;
        #1;
        model_reset();
        check_outputs();
        in_valid = 1'b0;
        hold     = 1'b0;
        flush    = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    function automatic logic [PW-1:0] rnd_price(input int zero_pct);
        if (int'($urandom_range(99, 0)) < zero_pct) return '0;
        return PW'($urandom_range(255, 1));
    endfunction

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_buy    = '0;
        in_sell   = '0;
        out_ready = 1'b0;
        hold      = 1'b0;
        flush     = 1'b0;
        model_reset();
        #2;
        check_outputs();
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Single push becomes visible at the head the next cycle
        step(1'b1, 8'h40, 8'h3C, 1'b0, 1'b0, 1'b0);
        chk("lat_out_valid", 32'(out_valid), 32'd1);
        chk("lat_out_buy",   32'(out_buy),   32'h40);
        chk("lat_out_sell",  32'(out_sell),  32'h3C);
        chk("lat_level",     32'(level),     32'd1);
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);

        // Nine pushes into a depth-8 queue: last one overflows
        for (int i = 0; i < 9; i++) step(1'b1, rnd_price(0), rnd_price(0), 1'b0, 1'b0, 1'b0);
        chk("ovf_full",  32'(full),       32'd1);
        chk("ovf_ready", 32'(in_ready),   32'd0);
        chk("ovf_drops", 32'(drop_count), 32'd1);

        // Full queue: pop happens, push refused; then push accepted
        step(1'b1, 8'h11, 8'h22, 1'b1, 1'b0, 1'b0);
        chk("fullpop_level", 32'(level),      32'd7);
        chk("fullpop_drops", 32'(drop_count), 32'd2);
        step(1'b1, 8'h33, 8'h44, 1'b0, 1'b0, 1'b0);
        chk("refill_level",  32'(level),      32'd8);

        // Zero price discarded (flush first to make room)
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h00, 8'h55, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h55, 8'h00, 1'b0, 1'b0, 1'b0);

        // Hold blocks dispatch, flush empties, release returns to run
        for (int i = 0; i < 3; i++) step(1'b1, rnd_price(0), rnd_price(0), 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b1, 1'b1, 1'b0);
        step(1'b0, '0, '0, 1'b1, 1'b1, 1'b0);
        step(1'b0, '0, '0, 1'b1, 1'b1, 1'b1);
        step(1'b0, '0, '0, 1'b1, 1'b1, 1'b0);
        step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

        // Streaming with continuous pop across pointer wrap, reset mid-stream
        for (int i = 0; i < 20; i++) begin
            if (i == 12) reset_mid();
            step(1'b1, rnd_price(0), rnd_price(0), 1'b1, 1'b0, 1'b0);
        end
        for (int i = 0; i < 2; i++) step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

        // Long hold with constant arrivals drives drop_count to saturation
        for (int i = 0; i < 300; i++) step(1'b1, rnd_price(5), rnd_price(5), 1'b1, 1'b1, 1'b0);
        chk("drop_sat", 32'(drop_count), 32'd255);
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        reset_mid();

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            step(logic'(int'($urandom_range(99, 0)) < 70),
                 rnd_price(8), rnd_price(8),
                 logic'(int'($urandom_range(99, 0)) < 50),
                 logic'(int'($urandom_range(99, 0)) < 12),
                 logic'(int'($urandom_range(99, 0)) < 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule
